// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   sweep_state_t : clear-sweep FSM states (SWEEP while zeroing storage, READY after)
//   RF_ADDR_WIDTH / RF_DATA_WIDTH : default geometry
//   REG_ZERO      : index of the hard-wired zero register
package regfile_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } sweep_state_t;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int REG_ZERO      = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register marking an in-flight producer.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : restart request from the sweep logic; drops every busy bit
//   en           : file is usable (writes and allocations only count when high)
//   wen, waddr   : write port; a write retires the producer of waddr
//   alloc_en, alloc_addr : issue of a new producer for alloc_addr
//   flush        : drop every busy bit
//   busy         : current busy vector, bit 0 is always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic                       alloc_en,
  input  logic [ADDR_WIDTH-1:0]      alloc_addr,
  input  logic                       flush,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  // Order of the assignments encodes priority: a write retires the old
  // producer, a same-cycle alloc then re-marks it (new producer wins), and
  // flush/clear override both.
  always_comb begin
    busy_next = busy_reg;
    if (en && wen)
      busy_next[waddr] = 1'b0;
    if (en && alloc_en && alloc_addr != ADDR_WIDTH'(REG_ZERO))
      busy_next[alloc_addr] = 1'b1;
    if (flush || clear)
      busy_next = '0;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  assign busy = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, busy scoreboard
// and a post-reset clear sweep (storage itself has no reset).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : restart the clear sweep
//   init_done     : sweep finished, file usable
//   wen/waddr/wdata : single write port (index 0 discarded)
//   alloc_en/alloc_addr : mark a register busy
//   flush         : clear all busy bits
//   raddr/rdata/rready : NUM_RD packed read ports, port i at [i*W +: W]
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  output logic                         init_done,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic                         flush,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rready
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  sweep_state_t            state_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic                    init_done_reg;
  logic [DATA_WIDTH-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic                    wr_ok;

  // Sweep FSM: zero one entry per cycle, READY after the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SWEEP;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
    end else if (clear) begin
      state_reg     <= SWEEP;
      cnt_reg       <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        SWEEP: begin
          if (cnt_reg == ADDR_WIDTH'(DEPTH-1)) begin
            state_reg     <= READY;
            init_done_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign init_done = init_done_reg;
  assign wr_ok     = wen && init_done_reg && (waddr != ADDR_WIDTH'(REG_ZERO));

  // Storage has no reset so it can map to distributed RAM; the sweep and
  // functional writes never overlap because writes need init_done.
  always_ff @(posedge clk) begin
    if (state_reg == SWEEP)
      rf[cnt_reg] <= '0;
    else if (wr_ok)
      rf[waddr] <= wdata;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .en         (init_done_reg),
    .wen        (wen),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  hit;
      logic [DATA_WIDTH-1:0] rd_data;
      logic                  rd_ready;

      assign ra  = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit = (BYPASS != 0) && wen && (waddr == ra);

      always_comb begin
        rd_data  = '0;
        rd_ready = 1'b0;
        if (init_done_reg) begin
          if (ra == ADDR_WIDTH'(REG_ZERO)) begin
            rd_ready = 1'b1;
          end else if (hit) begin
            rd_data  = wdata;
            rd_ready = 1'b1;
          end else begin
            rd_data  = rf[ra];
            rd_ready = !busy[ra];
          end
        end
      end

      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd_data;
      assign rready[gi]                         = rd_ready;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst, clear, wen, alloc_en, flush;
  logic [AW-1:0]     waddr, alloc_addr;
  logic [DW-1:0]     wdata;
  logic [NR*AW-1:0]  raddr;

  logic              init_done_b, init_done_n;
  logic [NR*DW-1:0]  rdata_b, rdata_n;
  logic [NR-1:0]     rready_b, rready_n;

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .init_done(init_done_b),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .raddr(raddr), .rdata(rdata_b), .rready(rready_b)
  );

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .clear(clear), .init_done(init_done_n),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .raddr(raddr), .rdata(rdata_n), .rready(rready_n)
  );

  // Reference model: architectural register contents, busy flags and the
  // number of clock edges still needed before the file becomes usable.
  logic [DW-1:0] m_rf   [DEPTH];
  bit            m_busy [DEPTH];
  int            m_remain;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
    m_remain = DEPTH;
  endtask

  // Expected read result for one port given current inputs.
  task automatic exp_read(input bit byp, input logic [AW-1:0] ra,
                          output logic [DW-1:0] d, output logic r);
    d = '0;
    r = 1'b0;
    if (m_remain == 0) begin
      if (ra == 0) begin
        r = 1'b1;
      end else if (byp && wen && waddr == ra) begin
        d = wdata;
        r = 1'b1;
      end else begin
        d = m_rf[ra];
        r = !m_busy[ra];
      end
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] ra;
    logic [DW-1:0] ed;
    logic          er;
    chk("init_done_byp", DW'(init_done_b), DW'(m_remain == 0));
    chk("init_done_nobyp", DW'(init_done_n), DW'(m_remain == 0));
    for (int p = 0; p < NR; p++) begin
      ra = raddr[p*AW +: AW];
      exp_read(1'b1, ra, ed, er);
      chk($sformatf("rdata%0d_byp ra=%0d", p, ra), rdata_b[p*DW +: DW], ed);
      chk($sformatf("rready%0d_byp ra=%0d", p, ra), DW'(rready_b[p]), DW'(er));
      exp_read(1'b0, ra, ed, er);
      chk($sformatf("rdata%0d_nobyp ra=%0d", p, ra), rdata_n[p*DW +: DW], ed);
      chk($sformatf("rready%0d_nobyp ra=%0d", p, ra), DW'(rready_n[p]), DW'(er));
    end
  endtask

  // State change at a clock edge, from the current inputs.
  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (m_remain > 0) begin
      m_remain--;
    end else begin
      if (wen && waddr != 0) m_rf[waddr] = wdata;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end else begin
        if (wen) m_busy[waddr] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end
    end
  endtask

  // Inputs are set at posedge+1; check at posedge+2, then advance one edge.
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 0; wen = 0; alloc_en = 0; flush = 0;
    waddr = '0; wdata = '0; alloc_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_rd(5'd5, 5'd0);
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Init sweep: 32 edges with init_done low, then usable.
    for (int i = 0; i < DEPTH; i++) step();
    #1;
    chk("init_done_at_32", DW'(init_done_b), 32'd1);
    chk("rf5_after_sweep", rdata_b[DW-1:0], 32'd0);

    // Write with same-cycle read: bypass vs no bypass.
    wen = 1; waddr = 5'd3; wdata = 32'hDEADBEEF; set_rd(5'd0, 5'd3);
    #1;
    chk("bypass_same_cycle", rdata_b[DW +: DW], 32'hDEADBEEF);
    chk("nobypass_same_cycle", rdata_n[DW +: DW], 32'h0);
    step();
    idle();
    #1;
    chk("nobypass_next_cycle", rdata_n[DW +: DW], 32'hDEADBEEF);
    step();

    // Zero register: write and alloc of index 0 have no effect.
    wen = 1; waddr = 5'd0; wdata = 32'h12345678; set_rd(5'd0, 5'd0);
    step();
    idle(); alloc_en = 1; alloc_addr = 5'd0;
    step();
    idle();
    #1;
    chk("zero_reg_ready", DW'(rready_b[0]), 32'd1);
    step();

    // Scoreboard: alloc, retire by write, alloc+write same index.
    alloc_en = 1; alloc_addr = 5'd7; set_rd(5'd7, 5'd3);
    step();
    idle();
    #1;
    chk("busy_after_alloc", DW'(rready_b[0]), 32'd0);
    step();
    wen = 1; waddr = 5'd7; wdata = 32'hA5;
    step();
    idle();
    step();
    alloc_en = 1; alloc_addr = 5'd7; wen = 1; waddr = 5'd7; wdata = 32'h5A;
    step();
    idle();
    #1;
    chk("alloc_wins_over_write", DW'(rready_n[0]), 32'd0);
    step();

    // Flush beats a same-cycle alloc.
    alloc_en = 1; alloc_addr = 5'd4;  step();
    alloc_addr = 5'd9;                step();
    alloc_addr = 5'd31;               step();
    alloc_addr = 5'd10; flush = 1; set_rd(5'd31, 5'd10);
    step();
    idle();
    step();
    set_rd(5'd4, 5'd9);
    step();

    // Restart via clear, then async reset mid-sweep.
    wen = 1; waddr = 5'd2; wdata = 32'h55; set_rd(5'd2, 5'd3);
    step();
    idle(); clear = 1;
    step();
    idle(); wen = 1; waddr = 5'd2; wdata = 32'h77;
    for (int i = 0; i < 10; i++) step();
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) step();
    idle();
    #1;
    chk("reg2_after_restart", rdata_b[DW-1:0], 32'd0);
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      wen        = ($urandom % 2) == 0;
      waddr      = ($urandom % 4 == 0) ? AW'($urandom % DEPTH) : AW'($urandom_range(1, 7));
      wdata      = $urandom;
      alloc_en   = ($urandom % 3) == 0;
      alloc_addr = ($urandom % 4 == 0) ? AW'($urandom % DEPTH) : AW'($urandom_range(0, 7));
      flush      = ($urandom % 16) == 0;
      clear      = ($urandom % 150) == 0;
      set_rd(($urandom % 2) ? waddr : AW'($urandom_range(0, 7)),
             ($urandom % 2) ? alloc_addr : AW'($urandom % DEPTH));
      if (i == 200) pulse_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
